// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that owns the select of a shared N:1 mux.
// A grant is held until the last beat of the winner's burst or an idle timeout.
module rr_mux_arbiter #(
    parameter int N       = 16,
    parameter int RANGE   = 4,
    parameter int DATA_W  = 1,
    parameter int TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req,
    input  logic [N*DATA_W-1:0]   data_in,
    input  logic [N-1:0]          last,
    input  logic                  out_ready,
    output logic [RANGE-1:0]      sel,
    output logic [N-1:0]          grant,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_last,
    output logic                  busy
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state_q, state_d;
    logic [RANGE-1:0] sel_d, ptr_q, ptr_d, win, nxt;
    logic [N-1:0]     grant_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             found, xfer, expire;

    // First requester at or after ptr, wrapping at N (N need not be 2**RANGE)
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = RANGE'(idx);
            end
        end
    end

    assign nxt       = (sel == RANGE'(N - 1)) ? '0 : sel + 1'b1;
    assign busy      = (state_q == GRANT);
    assign out_valid = busy & req[sel];
    assign out_last  = busy & last[sel];
    assign out_data  = data_in[int'(sel)*DATA_W +: DATA_W];
    assign xfer      = out_valid & out_ready;
    assign expire    = (TIMEOUT != 0) && busy && !req[sel]
                       && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        sel_d   = sel;
        grant_d = grant;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    sel_d   = win;
                    grant_d = N'(1) << win;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if ((xfer && out_last) || expire) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = nxt;
                end else if (req[sel]) begin
                    cnt_d = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel     <= '0;
            grant   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel     <= sel_d;
            grant   <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
